prime_generator: RTL and testbench

Sequential counterpart to the combinational prime detector. On a start pulse it walks candidates 2 .. 2^WIDTH-1 in ascending order and tests each one by iterative trial division, one divisor per clock. Each prime found is emitted on a valid/ready stream. The block serves as the stimulus and reference source for prime-related datapaths and can feed a detector directly.

---
 rtl/prime_generator.sv | 114 +++++++++++
 tb/tb_prime_generator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_generator.sv
// Sequential prime generator: sweeps candidates 2 .. 2^WIDTH-1 in ascending
// order, tests each by trial division (one divisor per clock) and emits every
// prime on a valid/ready stream. All outputs are registered, so prime_ready
// has no combinational path to prime_valid or prime_out.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   TEST  | trying divisor d against candidate c, one divisor per cycle
//   EMIT  | prime_out holds a prime, waiting for the consumer handshake
//   DONE  | sweep finished at c = 2^WIDTH-1; done is sticky until start
module prime_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] prime_out,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prime_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_LAST = '1;
    localparam logic [WIDTH-1:0] D_INIT = WIDTH'(2);

    state_t             state;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   d;
    logic [2*WIDTH-1:0] d_sq;
    logic [2*WIDTH-1:0] c_wide;
    logic [WIDTH-1:0]   d_safe;
    logic [WIDTH-1:0]   c_rem;
    logic               c_is_last;

    // Divisor square at double width so d*d never overflows.
    assign d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign c_wide    = {{WIDTH{1'b0}}, c};
    // d is 0 only outside TEST, where the remainder is unused; avoid divide-by-zero.
    assign d_safe    = (d == '0) ? WIDTH'(1) : d;
    assign c_rem     = c % d_safe;
    assign c_is_last = (c == C_LAST);

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            c           <= '0;
            d           <= '0;
            prime_out   <= '0;
            prime_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            prime_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= TEST;
                        c           <= D_INIT;
                        d           <= D_INIT;
                        prime_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                TEST: begin
                    if (d_sq > c_wide) begin
                        state       <= EMIT;
                        prime_out   <= c;
                        prime_valid <= 1'b1;
                    end else if (c_rem == '0) begin
                        if (c_is_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            c <= c + 1'b1;
                            d <= D_INIT;
                        end
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                EMIT: begin
                    if (prime_ready) begin
                        prime_valid <= 1'b0;
                        prime_count <= prime_count + 1'b1;
                        if (c_is_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= TEST;
                            c     <= c + 1'b1;
                            d     <= D_INIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_generator.sv
// Bench for prime_generator: an 8-bit and a 4-bit instance checked against a
// sieve-built list of primes.
module tb_prime_generator;

    logic       clk;
    logic       rst_n;
    logic       start8, rdy8, start4, rdy4;
    logic [7:0] out8, cnt8;
    logic [3:0] out4, cnt4;
    logic       valid8, busy8, done8;
    logic       valid4, busy4, done4;

    int n_tests;
    int n_fail;

    int ref8[$];
    int ref4[$];

    prime_generator #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .prime_out(out8), .prime_valid(valid8), .prime_ready(rdy8),
        .busy(busy8), .done(done8), .prime_count(cnt8)
    );

    prime_generator #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .prime_out(out4), .prime_valid(valid4), .prime_ready(rdy4),
        .busy(busy4), .done(done4), .prime_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sieve of Eratosthenes up to max, returned as an ascending list.
    task automatic build_ref(input int max, output int q[$]);
        bit comp[256];
        q = {};
        for (int i = 0; i < 256; i++) comp[i] = 1'b0;
        for (int i = 2; i <= max; i++) begin
            if (!comp[i]) begin
                q.push_back(i);
                for (int j = i * i; j <= max; j += i) comp[j] = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        start8 = 1'b0; start4 = 1'b0; rdy8 = 1'b0; rdy4 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait for a pending prime, accept it with a one-cycle ready pulse.
    task automatic get_prime8(output logic [7:0] val, output bit ok);
        int n;
        n = 0; ok = 1'b0; val = '0;
        rdy8 = 1'b0;
        while (!valid8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (valid8) begin
            ok = 1'b1;
            val = out8;
            rdy8 = 1'b1;
            @(negedge clk);
            rdy8 = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({out8, valid8, busy8, done8, cnt8} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset8: out=%0d valid=%0b busy=%0b done=%0b cnt=%0d, want all 0",
                     out8, valid8, busy8, done8, cnt8);
        end
        n_tests++;
        if ({out4, valid4, busy4, done4, cnt4} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset4: out=%0d valid=%0b busy=%0b done=%0b cnt=%0d, want all 0",
                     out4, valid4, busy4, done4, cnt4);
        end
    endtask

    task automatic test_first_primes();
        int got[$];
        int n;
        bit busy_ok;
        apply_reset();
        rdy8 = 1'b1;
        pulse_start8();
        n_tests++;
        if (valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid=%0b one cycle after start, want 0", valid8);
        end
        @(negedge clk);
        n_tests++;
        if (valid8 !== 1'b1 || out8 !== 8'd2) begin
            n_fail++;
            $display("FAIL latency: valid=%0b out=%0d two cycles after start, want 1/2", valid8, out8);
        end
        n = 0; busy_ok = 1'b1;
        while (got.size() < 6 && n < 500) begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            if (valid8) got.push_back(int'(out8));
            @(negedge clk);
            n++;
        end
        rdy8 = 1'b0;
        n_tests++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL busy_first: busy dropped during first primes, want 1");
        end
        n_tests++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL first_count: got %0d primes, want 6", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_tests++;
            if (got[i] != ref8[i]) begin
                n_fail++;
                $display("FAIL first_seq[%0d]: got %0d, want %0d", i, got[i], ref8[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v;
        bit ok;
        int n;
        apply_reset();
        pulse_start8();
        for (int i = 0; i < 3; i++) get_prime8(v, ok);
        n = 0;
        while (!valid8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (valid8 !== 1'b1 || out8 !== 8'd7 || cnt8 !== 8'd3) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%0b out=%0d cnt=%0d, want 1/7/3", i, valid8, out8, cnt8);
            end
            @(negedge clk);
        end
        rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0;
        n_tests++;
        if (cnt8 !== 8'd4 || valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_accept: cnt=%0d valid=%0b, want 4/0", cnt8, valid8);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        bit ok;
        int n;
        apply_reset();
        pulse_start8();
        for (int i = 0; i < 5; i++) get_prime8(v, ok);
        n = 0;
        while (!valid8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (valid8 !== 1'b1 || out8 !== 8'd13) begin
            n_fail++;
            $display("FAIL pend13: valid=%0b out=%0d, want 1/13", valid8, out8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (valid8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || cnt8 !== 8'd0) begin
            n_fail++;
            $display("FAIL async_rst: valid=%0b busy=%0b done=%0b cnt=%0d, want all 0",
                     valid8, busy8, done8, cnt8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst[%0d]: valid=%0b busy=%0b done=%0b, want 0", i, valid8, busy8, done8);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] v;
        bit ok;
        int n;
        apply_reset();
        pulse_start8();
        for (int i = 0; i < 3; i++) get_prime8(v, ok);
        pulse_start8();
        for (int i = 3; i < 5; i++) begin
            get_prime8(v, ok);
            n_tests++;
            if (!ok || int'(v) != ref8[i]) begin
                n_fail++;
                $display("FAIL busy_start[%0d]: got %0d ok=%0b, want %0d", i, v, ok, ref8[i]);
            end
        end
        rdy8 = 1'b1;
        n = 0;
        while (!done8 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        rdy8 = 1'b0;
        n_tests++;
        if (done8 !== 1'b1 || cnt8 !== 8'd54) begin
            n_fail++;
            $display("FAIL sweep_end: done=%0b cnt=%0d, want 1/54", done8, cnt8);
        end
        pulse_start8();
        n_tests++;
        if (done8 !== 1'b0 || cnt8 !== 8'd0 || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: done=%0b cnt=%0d busy=%0b, want 0/0/1", done8, cnt8, busy8);
        end
        get_prime8(v, ok);
        n_tests++;
        if (!ok || v !== 8'd2) begin
            n_fail++;
            $display("FAIL restart_first: got %0d ok=%0b, want 2", v, ok);
        end
    endtask

    task automatic test_full_sweep();
        int got[$];
        int n;
        bit busy_ok;
        apply_reset();
        pulse_start8();
        n = 0; busy_ok = 1'b1;
        while (!done8 && n < 30000) begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            rdy8 = 1'($urandom_range(0, 1));
            if (valid8 && rdy8) got.push_back(int'(out8));
            @(negedge clk);
            n++;
        end
        rdy8 = 1'b0;
        n_tests++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL sweep_busy: busy low mid-sweep, want 1");
        end
        n_tests++;
        if (got.size() != ref8.size()) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d primes, want %0d", got.size(), ref8.size());
        end
        for (int i = 0; i < got.size() && i < ref8.size(); i++) begin
            n_tests++;
            if (got[i] != ref8[i]) begin
                n_fail++;
                $display("FAIL sweep_seq[%0d]: got %0d, want %0d", i, got[i], ref8[i]);
            end
        end
        n_tests++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 8'd54 || valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_final: done=%0b busy=%0b cnt=%0d valid=%0b, want 1/0/54/0",
                     done8, busy8, cnt8, valid8);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (done8 !== 1'b1 || valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_sticky: done=%0b valid=%0b, want 1/0", done8, valid8);
        end
    endtask

    task automatic test_width4();
        int got[$];
        int n;
        apply_reset();
        rdy4 = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 2000) begin
            if (valid4) got.push_back(int'(out4));
            @(negedge clk);
            n++;
        end
        rdy4 = 1'b0;
        n_tests++;
        if (got.size() != ref4.size()) begin
            n_fail++;
            $display("FAIL w4_count: got %0d primes, want %0d", got.size(), ref4.size());
        end
        for (int i = 0; i < got.size() && i < ref4.size(); i++) begin
            n_tests++;
            if (got[i] != ref4[i]) begin
                n_fail++;
                $display("FAIL w4_seq[%0d]: got %0d, want %0d", i, got[i], ref4[i]);
            end
        end
        n_tests++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 4'd6) begin
            n_fail++;
            $display("FAIL w4_final: done=%0b busy=%0b cnt=%0d, want 1/0/6", done4, busy4, cnt4);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        build_ref(255, ref8);
        build_ref(15, ref4);
        test_reset();
        test_first_primes();
        test_backpressure();
        test_async_reset();
        test_start_while_busy();
        test_full_sweep();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
